alu_cmd_driver: RTL and testbench

Command-side front end for the 8-bit ALU. It accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. Each request is issued to the ALU as a one-cycle `alu_en` pulse with the operands held stable. The block waits for the ALU's `out_en` flag, allows the op-specific pipeline settle time, then captures the result and returns it over a valid/ready response port. It sits between the system controller and the ALU and is the only driver of the ALU's `a`, `b`, `sel` and `alu_en` inputs.

---
 rtl/alu_drv_pkg.sv | 48 ++++
 rtl/alu_drv_fifo.sv | 60 ++++++
 rtl/alu_cmd_driver.sv | 184 ++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU command driver: opcodes, FSM states,
// command record layout, default watchdog limit and the per-opcode settle table.
// No ports; imported by alu_drv_fifo and alu_cmd_driver.
package alu_drv_pkg;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_SHADD = 3'd5;
   localparam logic [2:0] OP_SUM3  = 3'd6;
   localparam logic [2:0] OP_MAC6  = 3'd7;

   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_EN,
      ST_SETTLE,
      ST_RESP
   } state_e;

   // One buffered request, {sel,a,b}.
   typedef struct packed {
      logic [2:0] sel;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // Extra cycles the ALU pipeline needs after out_en before alu_out is final.
   function automatic logic [1:0] settle_cycles(input logic [2:0] sel);
      logic [1:0] n;
      n = 2'd1;
      case (sel)
         OP_ADD, OP_SUB:         n = 2'd1;
         OP_AND, OP_OR, OP_XOR:  n = 2'd0;
         OP_SHADD:               n = 2'd2;
         OP_SUM3, OP_MAC6:       n = 2'd1;
         default:                n = 2'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/alu_drv_fifo.sv
// Purpose: synchronous command FIFO, DEPTH entries of W bits, head read combinationally.
// Latency: a push is visible at the head (and in count/empty) the cycle after the push edge.
// Backpressure: full_o comes from the registered count; a same-cycle pop does not free a slot early.
// Ports: clk/rst (sync, active-high); wr_vld_i/wr_dat_i push side (ignored when full);
//        rd_pop_i pop (ignored when empty); rd_dat_o head entry; full_o/empty_o/count_o status.
module alu_drv_fifo
   import alu_drv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = CMD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_vld_i,
   input  logic [W-1:0]             wr_dat_i,
   input  logic                     rd_pop_i,
   output logic [W-1:0]             rd_dat_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          wr_en, rd_en;

   assign full_o   = (count_q == CW'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign rd_dat_o = mem_q[rd_ptr_q];

   assign wr_en = wr_vld_i && !full_o;
   assign rd_en = rd_pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_dat_i;
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// Purpose: buffers ALU requests, issues each as a one-cycle alu_en pulse, waits out_en + settle, returns result.
// Latency: idle block, ALU out_en one cycle after sampling alu_en -> rsp_valid 4+SETTLE(sel) edges after accept.
// Backpressure: cmd_ready=!full (registered count); rsp_ready=0 parks the FSM in RESP while the FIFO keeps filling.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_sel request side;
//        rsp_valid/rsp_ready/rsp_data/rsp_sel/rsp_err response side; alu_a/alu_b/alu_sel/alu_en to the ALU;
//        alu_out/alu_out_en from the ALU.
// Build option: define ALU_DRV_TIMEOUT_EN to enable the WAIT_EN watchdog (TIMEOUT cycles, reports rsp_err).
module alu_cmd_driver
   import alu_drv_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic [2:0] cmd_sel,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [2:0] rsp_sel,
   output logic       rsp_err,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_sel,
   output logic       alu_en,
   input  logic [7:0] alu_out,
   input  logic       alu_out_en
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_e        state_q, state_d;
   cmd_t          cmd_in, head;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_cnt;
   logic          push, pop;

   logic [7:0]    alu_a_q, alu_b_q;
   logic [2:0]    alu_sel_q;
   logic [1:0]    settle_q, settle_d;
   logic [1:0]    settle_need;
   logic [7:0]    rsp_data_q;
   logic [2:0]    rsp_sel_q;
   logic          capture;
   logic          timeout_hit;

   // ---------------- command FIFO ----------------
   assign cmd_in    = '{sel: cmd_sel, a: cmd_a, b: cmd_b};
   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;
   assign pop       = (state_q == ST_RESP) && rsp_ready;

   alu_drv_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_vld_i (push),
      .wr_dat_i (cmd_in),
      .rd_pop_i (pop),
      .rd_dat_o (head),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .count_o  (fifo_cnt)
   );

   // ---------------- ALU drive ----------------
   // During ISSUE the operands come straight from the FIFO head; the registers
   // copy them on the same edge and keep them stable through capture and beyond.
   assign alu_en  = (state_q == ST_ISSUE);
   assign alu_a   = alu_en ? head.a   : alu_a_q;
   assign alu_b   = alu_en ? head.b   : alu_b_q;
   assign alu_sel = alu_en ? head.sel : alu_sel_q;

   assign settle_need = settle_cycles(alu_sel_q);

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_sel   = rsp_sel_q;

`ifdef ALU_DRV_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            rsp_err_q;

   // Counts cycles spent in WAIT_EN; any other state clears it, so it restarts on every entry.
   assign wd_d    = (state_q == ST_WAIT_EN) ? wd_q + WD_W'(1) : '0;
   assign rsp_err = rsp_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q      <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         if (capture)          rsp_err_q <= 1'b0;
         else if (timeout_hit) rsp_err_q <= 1'b1;
      end
   end
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
   assign rsp_err        = 1'b0;
`endif

   // ---------------- FSM ----------------
   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_EN;
         end
         ST_WAIT_EN: begin
            if (alu_out_en) begin
               if (settle_need != 2'd0) begin
                  settle_d = settle_need - 2'd1;
                  state_d  = ST_SETTLE;
               end else begin
                  capture = 1'b1;
                  state_d = ST_RESP;
               end
            end
`ifdef ALU_DRV_TIMEOUT_EN
            else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_d     = ST_RESP;
            end
`endif
         end
         ST_SETTLE: begin
            if (settle_q == 2'd0) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end else begin
               settle_d = settle_q - 2'd1;
            end
         end
         ST_RESP: begin
            // A same-cycle push also counts as a remaining entry.
            if (rsp_ready) state_d = ((fifo_cnt > CW'(1)) || push) ? ST_ISSUE : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         settle_q   <= 2'd0;
         alu_a_q    <= 8'd0;
         alu_b_q    <= 8'd0;
         alu_sel_q  <= 3'd0;
         rsp_data_q <= 8'd0;
         rsp_sel_q  <= 3'd0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         if (state_q == ST_ISSUE) begin
            alu_a_q   <= head.a;
            alu_b_q   <= head.b;
            alu_sel_q <= head.sel;
         end
         if (capture) begin
            rsp_data_q <= alu_out;
            rsp_sel_q  <= alu_sel_q;
         end else if (timeout_hit) begin
            rsp_data_q <= 8'd0;
            rsp_sel_q  <= alu_sel_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready;
   logic [7:0] cmd_a, cmd_b;
   logic [2:0] cmd_sel;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data;
   logic [2:0] rsp_sel;
   logic       rsp_err;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_sel;
   logic       alu_en;
   logic [7:0] alu_out;
   logic       alu_out_en;

   always #5 clk = ~clk;

   alu_cmd_driver #(.DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_sel(rsp_sel), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_en(alu_en),
      .alu_out(alu_out), .alu_out_en(alu_out_en)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- ALU model ----------------
   // Samples alu_en on an edge, raises out_en on the following edge, and shows
   // 0xEE on alu_out until the op-specific settle time has elapsed.
   logic       model_on = 1'b1;
   logic       spur     = 1'b0;
   logic       m_pend   = 1'b0;
   logic       m_out_en = 1'b0;
   logic [7:0] m_res    = 8'h00;
   logic [7:0] m_out    = 8'h00;
   int         m_s      = 0;
   int         m_cd     = 0;

   assign alu_out_en = m_out_en | spur;
   assign alu_out    = m_out;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      logic [8:0] t;
      t = {1'b0, a} + {1'b0, b};
      case (s)
         3'd0: return t[8:1];
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return (a << 1) + b;
         3'd6: return a + b + 8'd1;
         default: return (a * 8'd6) + b;
      endcase
   endfunction

   function automatic int settle_tb(input logic [2:0] s);
      case (s)
         3'd2, 3'd3, 3'd4: return 0;
         3'd5:             return 2;
         default:          return 1;
      endcase
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_pend   <= 1'b0;
         m_out_en <= 1'b0;
         m_cd     <= 0;
      end else begin
         m_pend   <= alu_en && model_on;
         m_out_en <= m_pend;
         if (alu_en) begin
            m_res <= alu_fn(alu_a, alu_b, alu_sel);
            m_s   <= settle_tb(alu_sel);
         end
         if (m_pend) begin
            if (m_s == 0) m_out <= m_res;
            else begin
               m_out <= 8'hEE;
               m_cd  <= m_s;
            end
         end else if (m_cd > 0) begin
            m_cd <= m_cd - 1;
            if (m_cd == 1) m_out <= m_res;
         end
      end
   end

   // ---------------- monitors ----------------
   int         en_cnt   = 0;
   int         stab_err = 0;
   logic       in_op    = 1'b0;
   logic [7:0] l_a, l_b;
   logic [2:0] l_sel;

   always @(posedge clk) begin
      if (alu_en) en_cnt <= en_cnt + 1;
      if (rst) in_op <= 1'b0;
      else if (alu_en) begin
         in_op <= 1'b1;
         l_a   <= alu_a;
         l_b   <= alu_b;
         l_sel <= alu_sel;
      end else if (in_op) begin
         if (alu_a !== l_a || alu_b !== l_b || alu_sel !== l_sel) stab_err <= stab_err + 1;
         if (rsp_valid) in_op <= 1'b0;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_data"},  rsp_data,  0);
      chk({tag, "_rsp_sel"},   rsp_sel,   0);
      chk({tag, "_rsp_err"},   rsp_err,   0);
      chk({tag, "_alu_a"},     alu_a,     0);
      chk({tag, "_alu_b"},     alu_b,     0);
      chk({tag, "_alu_sel"},   alu_sel,   0);
      chk({tag, "_alu_en"},    alu_en,    0);
   endtask

   // Drives one command; the following posedge is the acceptance edge.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      @(negedge clk);
      cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Returns the number of edges until rsp_valid is seen, 0 if the budget expires.
   task automatic wait_rsp(input int budget, output int lat);
      int n;
      n = 0; lat = 0;
      while (lat == 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         if (rsp_valid) lat = n;
      end
   endtask

   task automatic ack();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] sel;
      logic [7:0] exp_data;
      int         exp_lat;
   } vec_t;

   vec_t vecs [8];

   int   lat, e0, seen_v, seen_en;
   int   push_n, col_k, col_n;
   logic pushed;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      vecs[0] = '{8'h10, 8'h20, 3'd0, 8'h18, 5};
      vecs[1] = '{8'hF0, 8'h3C, 3'd2, 8'h30, 4};
      vecs[2] = '{8'h50, 8'h20, 3'd1, 8'h30, 5};
      vecs[3] = '{8'h0F, 8'hA0, 3'd3, 8'hAF, 4};
      vecs[4] = '{8'hFF, 8'h0F, 3'd4, 8'hF0, 4};
      vecs[5] = '{8'h03, 8'h04, 3'd5, 8'h0A, 6};
      vecs[6] = '{8'h01, 8'h02, 3'd6, 8'h04, 5};
      vecs[7] = '{8'h02, 8'h01, 3'd7, 8'h0D, 5};

      rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_sel = 3'd0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;

      // ---- single commands, one per opcode ----
      for (int i = 0; i < 8; i++) begin
         e0 = en_cnt;
         send(vecs[i].a, vecs[i].b, vecs[i].sel);
         wait_rsp(40, lat);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp_data);
         chk($sformatf("vec%0d_sel", i), rsp_sel, vecs[i].sel);
         chk($sformatf("vec%0d_err", i), rsp_err, 0);
         ack();
         chk($sformatf("vec%0d_valid_drop", i), rsp_valid, 0);
         chk($sformatf("vec%0d_en_pulses", i), en_cnt - e0, 1);
      end

      // ---- fill FIFO under response stall, then drain ----
      e0 = en_cnt;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("fill_ready%0d", i), cmd_ready, 1);
         cmd_a = vecs[i].a; cmd_b = vecs[i].b; cmd_sel = vecs[i].sel; cmd_valid = 1'b1;
         @(posedge clk);
         #1 cmd_valid = 1'b0;
      end
      @(negedge clk);
      chk("fill_full_ready", cmd_ready, 0);
      repeat (10) @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_ready", cmd_ready, 0);
      cmd_a = vecs[4].a; cmd_b = vecs[4].b; cmd_sel = vecs[4].sel; cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      fork
         begin
            pushed = 1'b0; push_n = 0;
            while (!pushed && push_n < 100) begin
               if (cmd_ready) begin
                  @(posedge clk);
                  #1 cmd_valid = 1'b0;
                  pushed = 1'b1;
               end else begin
                  @(negedge clk);
                  push_n++;
               end
            end
            chk("fill_push5", pushed, 1);
         end
         begin
            col_k = 0; col_n = 0;
            while (col_k < 5 && col_n < 300) begin
               if (rsp_valid) begin
                  chk($sformatf("drain%0d_data", col_k), rsp_data, vecs[col_k].exp_data);
                  chk($sformatf("drain%0d_sel", col_k), rsp_sel, vecs[col_k].sel);
                  @(posedge clk);
                  #1;
                  if (col_k < 4) chk($sformatf("b2b%0d_alu_en", col_k), alu_en, 1);
                  col_k++;
                  @(negedge clk);
               end else begin
                  @(negedge clk);
                  col_n++;
               end
            end
            chk("drain_count", col_k, 5);
         end
      join
      rsp_ready = 1'b0;
      chk("drain_en_pulses", en_cnt - e0, 5);

      // ---- reset in the middle of a SHADD settle, with a second command queued ----
      send(8'h03, 8'h04, 3'd5);
      send(8'h01, 8'h02, 3'd6);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_valid", rsp_valid, 0);
      chk("pre_rst_sel", alu_sel, 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs("midrst");
      rst = 1'b0;
      rsp_ready = 1'b1;
      seen_v = 0; seen_en = 0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid) seen_v++;
         if (alu_en) seen_en++;
      end
      rsp_ready = 1'b0;
      chk("midrst_no_rsp", seen_v, 0);
      chk("midrst_fifo_empty", seen_en, 0);

      // ---- spurious out_en while idle ----
      @(negedge clk);
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      seen_v = 0; seen_en = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) seen_v++;
         if (alu_en) seen_en++;
      end
      chk("spur_no_rsp", seen_v, 0);
      chk("spur_no_issue", seen_en, 0);
      send(vecs[0].a, vecs[0].b, vecs[0].sel);
      wait_rsp(40, lat);
      chk("post_spur_latency", lat, 5);
      chk("post_spur_data", rsp_data, 8'h18);
      ack();

      // ---- ALU never answers ----
      model_on = 1'b0;
      send(8'hF0, 8'h3C, 3'd2);
`ifdef ALU_DRV_TIMEOUT_EN
      wait_rsp(60, lat);
      chk("wd_latency", lat, 18);
      chk("wd_err", rsp_err, 1);
      chk("wd_data", rsp_data, 0);
      chk("wd_sel", rsp_sel, 2);
      ack();
      chk("wd_valid_drop", rsp_valid, 0);
`else
      seen_v = 0;
      repeat (100) begin
         @(negedge clk);
         if (rsp_valid) seen_v++;
      end
      chk("nowd_no_rsp", seen_v, 0);
      chk("nowd_err", rsp_err, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
`endif
      model_on = 1'b1;

      chk("operand_stability", stab_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
